score_display_mux: RTL

Display back-end for the scoreboard. It takes the 0–99 score value produced by the up/down score counter and converts it to two BCD digits with a sequential shift-and-add-3 (double-dabble) engine. It then time-multiplexes those digits onto a shared 7-segment bus with one-hot digit enables, and sits directly between the counter output and the board's display pins.

---
 rtl/score_display_mux.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/score_display_mux.sv
// Score display back-end: clamps the 0-99 score, converts it to BCD with a
// sequential double-dabble engine and multiplexes both digits onto one 7-segment bus.
module score_display_mux #(
  parameter int BW          = 7,
  parameter int REFRESH_DIV = 1000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] value_i,
  output logic [6:0]    seg_o,
  output logic [1:0]    digit_sel_o,
  output logic          busy_o
);

  localparam int XW = (BW > 7) ? BW : 7;
  localparam int IW = $clog2(BW + 1);
  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  state_t        state_q;
  logic [BW-1:0] bin_q;
  logic [7:0]    bcd_q;
  logic [IW-1:0] iter_q;
  logic [6:0]    val_q;
  logic [6:0]    last_q;
  logic [3:0]    tens_q;
  logic [3:0]    ones_q;
  logic          busy_q;

  logic [XW-1:0] val_x;
  logic [6:0]    val_c;
  logic [7:0]    bcd_adj;
  logic [BW+7:0] shift_w;

  assign val_x = XW'(value_i);
  assign val_c = (val_x > XW'(99)) ? 7'd99 : val_x[6:0];

  always_comb begin
    bcd_adj = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    shift_w = {bcd_adj, bin_q} << 1;
  end

  // Conversion engine: value_i is only looked at in IDLE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      val_q   <= '0;
      last_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (val_c != last_q) begin
            val_q   <= val_c;
            bin_q   <= BW'(val_c);
            bcd_q   <= '0;
            iter_q  <= IW'(BW);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q  <= shift_w[BW+7:BW];
          bin_q  <= shift_w[BW-1:0];
          iter_q <= iter_q - IW'(1);
          if (iter_q == IW'(1)) state_q <= LOAD;
        end
        LOAD: begin
          tens_q  <= bcd_q[7:4];
          ones_q  <= bcd_q[3:0];
          last_q  <= val_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tens_en_q, tens_en_d;
  logic [1:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;

  // Refresh and output register: the digit shown follows tens_en_q one cycle late
  always_comb begin
    cnt_d     = cnt_q + CW'(1);
    tens_en_d = tens_en_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d     = '0;
      tens_en_d = ~tens_en_q;
    end
    sel_d = tens_en_q ? 2'b10 : 2'b01;
    seg_d = seg_decode(ones_q);
    if (tens_en_q) begin
      seg_d = (BLANK_LZ && (tens_q == 4'd0)) ? 7'h00 : seg_decode(tens_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      tens_en_q <= 1'b0;
      sel_q     <= 2'b00;
      seg_q     <= 7'h00;
    end else begin
      cnt_q     <= cnt_d;
      tens_en_q <= tens_en_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

  assign seg_o       = seg_q;
  assign digit_sel_o = sel_q;
  assign busy_o      = busy_q;

endmodule
